// File: rtl/ultrasonic_burst_tx.sv
// Ultrasonic transmit sequencer: complementary tone burst, ring-down blank, then listen window.
// Optional driver dead-time is enabled by defining DEADTIME_EN.
module ultrasonic_burst_tx #(
    parameter int CLK_FREQ          = 100_000_000,
    parameter int EMITTED_FREQUENCY = 40000,
    parameter int BURST_CYCLES      = 8,
    parameter int BLANK_CYCLES      = 2000,
    parameter int LISTEN_CYCLES     = 100000,
    parameter int DEAD_CYCLES       = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       trigger_in,
    input  logic [7:0] burst_len_in,
    input  logic       abort_in,
    output logic       tx_out,
    output logic       tx_n_out,
    output logic       busy_out,
    output logic       burst_start_out,
    output logic       listen_out,
    output logic       done_out
);

    localparam int HALF_PERIOD = CLK_FREQ / (2 * EMITTED_FREQUENCY);
    localparam int HCNT_W      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int WAIT_MAX    = (BLANK_CYCLES > LISTEN_CYCLES) ? BLANK_CYCLES : LISTEN_CYCLES;
    localparam int WCNT_W      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

`ifdef DEADTIME_EN
    localparam bit DT_ON = 1'b1;
`else
    localparam bit DT_ON = 1'b0;
`endif

    localparam logic [HCNT_W-1:0] HP_LAST     = HCNT_W'(HALF_PERIOD - 1);
    localparam logic [HCNT_W-1:0] DEAD_LIM    = HCNT_W'(DEAD_CYCLES);
    localparam logic [WCNT_W-1:0] BLANK_LAST  = WCNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [WCNT_W-1:0] LISTEN_LAST = WCNT_W'(LISTEN_CYCLES - 1);
    localparam logic [7:0]        BURST_LAST  = 8'(BURST_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BURST, BLANK, LISTEN} state_t;

    state_t            state, state_nx;
    logic [HCNT_W-1:0] hcnt, hcnt_nx;
    logic              phase, phase_nx;
    logic [7:0]        cyc, cyc_nx;
    logic [WCNT_W-1:0] wcnt, wcnt_nx;
    logic              start_nx, done_nx, dead_ok;

    // phase=0 is the high half of a tone cycle; cyc counts tone cycles still to go after this one
    always_comb begin
        state_nx = state;
        hcnt_nx  = hcnt;
        phase_nx = phase;
        cyc_nx   = cyc;
        wcnt_nx  = wcnt;
        start_nx = 1'b0;
        done_nx  = 1'b0;
        if (state != IDLE && abort_in) begin
            state_nx = IDLE;
            hcnt_nx  = '0;
            phase_nx = 1'b0;
            cyc_nx   = '0;
            wcnt_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger_in) begin
                        state_nx = BURST;
                        hcnt_nx  = '0;
                        phase_nx = 1'b0;
                        cyc_nx   = (burst_len_in == 8'd0) ? BURST_LAST : burst_len_in - 8'd1;
                        wcnt_nx  = '0;
                        start_nx = 1'b1;
                    end
                end
                BURST: begin
                    if (hcnt == HP_LAST) begin
                        hcnt_nx = '0;
                        if (!phase) begin
                            phase_nx = 1'b1;
                        end else if (cyc == 8'd0) begin
                            phase_nx = 1'b0;
                            wcnt_nx  = '0;
                            state_nx = (BLANK_CYCLES > 0) ? BLANK : LISTEN;
                        end else begin
                            phase_nx = 1'b0;
                            cyc_nx   = cyc - 8'd1;
                        end
                    end else begin
                        hcnt_nx = hcnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (wcnt == BLANK_LAST) begin
                        state_nx = LISTEN;
                        wcnt_nx  = '0;
                    end else begin
                        wcnt_nx = wcnt + 1'b1;
                    end
                end
                LISTEN: begin
                    if (wcnt == LISTEN_LAST) begin
                        state_nx = IDLE;
                        wcnt_nx  = '0;
                        done_nx  = 1'b1;
                    end else begin
                        wcnt_nx = wcnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        // Dead-time blanks the start of each half-period so both switches are never on together
        dead_ok = !DT_ON || (hcnt_nx >= DEAD_LIM);
    end

    // Outputs are registered from next-state values so they line up with the state they describe
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            hcnt            <= '0;
            phase           <= 1'b0;
            cyc             <= '0;
            wcnt            <= '0;
            tx_out          <= 1'b0;
            tx_n_out        <= 1'b0;
            busy_out        <= 1'b0;
            burst_start_out <= 1'b0;
            listen_out      <= 1'b0;
            done_out        <= 1'b0;
        end else begin
            state           <= state_nx;
            hcnt            <= hcnt_nx;
            phase           <= phase_nx;
            cyc             <= cyc_nx;
            wcnt            <= wcnt_nx;
            tx_out          <= (state_nx == BURST) && !phase_nx && dead_ok;
            tx_n_out        <= (state_nx == BURST) && phase_nx && dead_ok;
            busy_out        <= (state_nx != IDLE);
            burst_start_out <= start_nx;
            listen_out      <= (state_nx == LISTEN);
            done_out        <= done_nx;
        end
    end

endmodule

// File: tb/tb_ultrasonic_burst_tx.sv
// Scoreboard bench for ultrasonic_burst_tx: timeline reference model feeds an expected-output queue.
module tb_ultrasonic_burst_tx;

    localparam int HP     = 4;
    localparam int BLANK  = 3;
    localparam int LISTEN = 5;
    localparam int BURSTC = 8;
    localparam int DEAD   = 1;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       trigger_in = 1'b0;
    logic [7:0] burst_len_in = 8'd0;
    logic       abort_in = 1'b0;
    logic       tx_out, tx_n_out, busy_out, burst_start_out, listen_out, done_out;

    ultrasonic_burst_tx #(
        .CLK_FREQ(320000),
        .EMITTED_FREQUENCY(40000),
        .BURST_CYCLES(BURSTC),
        .BLANK_CYCLES(BLANK),
        .LISTEN_CYCLES(LISTEN),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .trigger_in(trigger_in),
        .burst_len_in(burst_len_in),
        .abort_in(abort_in),
        .tx_out(tx_out),
        .tx_n_out(tx_n_out),
        .busy_out(busy_out),
        .burst_start_out(burst_start_out),
        .listen_out(listen_out),
        .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    // {tx, tx_n, busy, burst_start, listen, done}
    typedef logic [5:0] exp_t;
    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    // Model: k = clocks since the accepted trigger (1 = first burst clock), 0 = idle
    int m_k = 0;
    int m_n = 0;
    bit m_done = 1'b0;

    function automatic exp_t model_out(int k, int n, bit done);
        int b;
        bit burst, hi, dok, tx, txn;
        b     = 2 * HP * n;
        burst = (k >= 1) && (k <= b);
        hi    = (((k - 1) / HP) % 2) == 0;
        dok   = 1'b1;
`ifdef DEADTIME_EN
        dok   = ((k - 1) % HP) >= DEAD;
`endif
        tx    = burst && hi && dok;
        txn   = burst && !hi && dok;
        return {tx, txn, k >= 1, k == 1, k > b + BLANK, done};
    endfunction

    task automatic step(input bit rst, input bit trig, input logic [7:0] len, input bit ab);
        int total;
        @(negedge clk_in);
        rst_in       = rst;
        trigger_in   = trig;
        burst_len_in = len;
        abort_in     = ab;
        total  = 2 * HP * m_n + BLANK + LISTEN;
        m_done = 1'b0;
        if (!rst) m_k = 0;
        else if (m_k != 0 && ab) m_k = 0;
        else if (m_k == 0) begin
            if (trig) begin
                m_k = 1;
                m_n = (len == 8'd0) ? BURSTC : int'(len);
            end
        end else if (m_k == total) begin
            m_k    = 0;
            m_done = 1'b1;
        end else m_k++;
        exp_q.push_back(model_out(m_k, m_n, m_done));
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge clk_in);
            #2;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {tx_out, tx_n_out, busy_out, burst_start_out, listen_out, done_out};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d got tx,txn,busy,start,listen,done=%b expected=%b",
                             cycle, a, e);
                end
            end
        end
    end

    initial begin : stimulus
        // reset, with a trigger that must be ignored
        step(0, 0, 8'd0, 0);
        step(0, 1, 8'd2, 0);
        step(0, 0, 8'd0, 0);
        // short burst, re-trigger during burst ignored, trigger on done cycle accepted
        step(1, 1, 8'd2, 0);
        for (int c = 1; c <= 30; c++) step(1, (c == 10) || (c == 25), 8'd2, 0);
        repeat (30) step(1, 0, 8'd0, 0);
        // default length burst
        step(1, 1, 8'd0, 0);
        repeat (80) step(1, 0, 8'd5, 0);
        // abort mid-burst then clean restart
        step(1, 1, 8'd2, 0);
        for (int c = 1; c <= 30; c++) step(1, c == 9, 8'd1, c == 7);
        // abort in idle has no effect; abort with trigger in idle starts a burst
        step(1, 0, 8'd0, 1);
        step(1, 1, 8'd1, 1);
        repeat (20) step(1, 0, 8'd0, 0);
        // reset mid-burst, trigger during reset ignored
        step(1, 1, 8'd3, 0);
        for (int c = 1; c <= 10; c++) step(!(c == 3 || c == 4), c == 4, 8'd1, 0);
        repeat (10) step(1, 0, 8'd0, 0);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 400) != 0, ($urandom % 8) == 0,
                 8'($urandom_range(0, 3)), ($urandom % 150) == 0);
        end
        repeat (120) step(1, 0, 8'd0, 0);
        @(posedge clk_in);
        #3;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
